crc32_frame_ctrl: RTL
=====================

// Module: crc32_frame_ctrl
// PURPOSE
//  Frame sequencer for the 64-bit-per-cycle CRC-32 datapath. Takes framed 64-bit beats (sof/eof/byte count),
//  seeds the CRC state at frame start and folds full words in one cycle. It walks a partial last word one byte
//  per cycle, then applies the final XOR and holds the result until the consumer accepts it.
//  Sits between the packet source and the TX append / RX check logic.
// PARAMETERS
//  CRC_INIT    32'hFFFFFFFF  seed loaded at sof
//  CRC_XOROUT  32'hFFFFFFFF  XOR applied to the state to form crc_out
//  CNT_W       16            width of beat_cnt (saturating)
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst_n      in   1      asynchronous reset, active low
//  s_valid    in   1      input beat valid
//  s_ready    out  1      input beat accepted when s_valid & s_ready
//  s_data     in   64     beat data; byte k = s_data[8k+7:8k], byte 0 first, each byte LSB first
//  s_sof      in   1      first beat of frame
//  s_eof      in   1      last beat of frame
//  s_bytes    in   4      valid low-order bytes on eof beat, 1..8; 0 or >8 treated as 8; ignored if !s_eof
//  crc_valid  out  1      result available, held until crc_ready
//  crc_ready  in   1      consumer takes result
//  crc_out    out  32     final CRC (state ^ CRC_XOROUT), stable while crc_valid
//  beat_cnt   out  CNT_W  beats accepted in current/last frame, saturates at all-ones
//  frame_err  out  1      one-cycle pulse: orphan beat dropped or frame restarted
// BEHAVIOUR
//  CRC: reflected CRC-32, poly 0x04C11DB7 (reflected 0xEDB88320); word step == eight byte steps in byte order.
//  Reset (rst_n=0, async): state IDLE, crc reg = CRC_INIT, crc_valid=0, crc_out=0, beat_cnt=0, frame_err=0.
//  s_ready = 1 in IDLE and RUN, 0 in TAIL and DONE (combinational from state).
//  IDLE: accepted beat with sof: crc = step(CRC_INIT, data), beat_cnt=1.
//        accepted beat without sof: dropped, frame_err pulse, crc/beat_cnt unchanged.
//  RUN:  accepted beat: crc = step(crc, data), beat_cnt++ (saturating).
//        sof on a RUN beat: frame restarts from CRC_INIT with this beat, beat_cnt=1, frame_err pulse.
//  eof beat with effective bytes n: n=8 -> full-word step, go DONE.
//        n<8 -> capture word and n, crc unchanged, go TAIL.
//        sof&eof is a one-beat frame, seeded from CRC_INIT.
//  TAIL: one byte step per cycle, bytes 0..n-1 of captured word; after byte n-1, go DONE.
//  DONE: crc_valid=1, crc_out=crc^CRC_XOROUT. On crc_ready -> IDLE next cycle, crc_valid=0,
//        crc reg reloads CRC_INIT. crc_out holds its last value.
//  Latency: full eof beat accepted at cycle t -> crc_valid at t+1. Partial (n bytes) -> crc_valid at t+1+n.
//  One bubble per frame: the next sof beat is accepted no earlier than the cycle after crc_ready.
//  Reset mid-frame or with crc_valid high: frame discarded, no crc_valid issued.
//  s_valid low inside a frame: state held, no timeout.
// CONFIGURATION
//  CRC_CHECK_EN defined: adds crc_exp (in, 32) and crc_match (out, 1).
//    crc_exp is sampled on the eof beat. crc_match = (crc_out == sampled crc_exp), valid while crc_valid,
//    reset 0, cleared on leaving DONE.
//  CRC_CHECK_EN undefined: neither port exists, no comparator or capture register.
// TESTING
//  1. sof beat 64'h3837363534333231, then eof beat data 64'h39, s_bytes=1 -> crc_valid 2 cycles after eof,
//     crc_out=32'hCBF43926, beat_cnt=2.
//  2. Test 1 with s_valid gaps and crc_ready held low 5 cycles -> same crc_out.
//     crc_valid/crc_out stable for 5 cycles, s_ready=0 throughout.
//  3. Beat without sof in IDLE -> frame_err pulse, beat_cnt=0, no crc_valid.
//     Then test 1 -> 32'hCBF43926.
//  4. 3-beat frame with a second sof on beat 2, followed by test-1 beats as the tail of the new frame
//     -> frame_err pulse, beat_cnt restarts at 1, final crc_out equals a standalone frame of the same beats.
//  5. rst_n low in TAIL -> crc_valid=0, beat_cnt=0, s_ready=1 after release.
//     A new test-1 frame -> 32'hCBF43926.
//  6. CRC_CHECK_EN: test 1 with crc_exp=32'hCBF43926 -> crc_match=1.
//     With crc_exp=32'hCBF43927 -> crc_match=0.

Source files
------------

// File: rtl/crc32_frame_ctrl.sv
// crc32_frame_ctrl: frame sequencer for a 64-bit-per-cycle reflected CRC-32.
// Full words fold in one cycle. A partial last word is walked one byte per cycle.
// The result is held until the consumer accepts it.
// Optional feature macro: CRC_CHECK_EN adds crc_exp/crc_match compare against an expected CRC.
module crc32_frame_ctrl #(
  parameter logic [31:0] CRC_INIT   = 32'hFFFF_FFFF,
  parameter logic [31:0] CRC_XOROUT = 32'hFFFF_FFFF,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [63:0]      s_data,
  input  logic             s_sof,
  input  logic             s_eof,
  input  logic [3:0]       s_bytes,
  output logic             crc_valid,
  input  logic             crc_ready,
  output logic [31:0]      crc_out,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             frame_err
`ifdef CRC_CHECK_EN
  ,
  input  logic [31:0]      crc_exp,
  output logic             crc_match
`endif
);

  localparam int unsigned CRC_W   = 32;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned TAIL_W  = 3;
  localparam logic [CRC_W-1:0] POLY_REF = 32'hEDB8_8320;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_TAIL, ST_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [CRC_W-1:0]    r_crc, w_crc_nxt;
  logic [DATA_W-1:0]   r_tail_word, w_tail_word_nxt;
  logic [TAIL_W-1:0]   r_tail_left, w_tail_left_nxt;
  logic                r_crc_valid, w_valid_nxt;
  logic [CRC_W-1:0]    r_crc_out, w_out_nxt;
  logic [CNT_W-1:0]    r_beat_cnt, w_cnt_nxt;
  logic                r_frame_err, w_err_nxt;
`ifdef CRC_CHECK_EN
  logic [CRC_W-1:0]    r_crc_exp, w_exp_nxt;
  logic                r_crc_match, w_match_nxt;
`endif

  logic                w_fire;
  logic [3:0]          w_eff_n;
  logic [CRC_W-1:0]    w_base;
  logic [CRC_W-1:0]    w_word_crc;
  logic [CRC_W-1:0]    w_byte_crc;
  logic [CNT_W-1:0]    w_cnt_inc;

  // One reflected CRC-32 byte step, bits consumed LSB first.
  function automatic logic [CRC_W-1:0] crc_byte(input logic [CRC_W-1:0] c, input logic [7:0] b);
    logic [CRC_W-1:0] r;
    r = c ^ {24'h00_0000, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ POLY_REF) : (r >> 1);
    end
    return r;
  endfunction

  // Full-word step: eight byte steps, byte 0 first.
  function automatic logic [CRC_W-1:0] crc_word(input logic [CRC_W-1:0] c, input logic [DATA_W-1:0] d);
    logic [CRC_W-1:0] r;
    r = c;
    for (int k = 0; k < 8; k++) begin
      r = crc_byte(r, d[8*k +: 8]);
    end
    return r;
  endfunction

  assign s_ready    = (r_state == ST_IDLE) || (r_state == ST_RUN);
  assign w_fire     = s_valid && s_ready;
  assign w_eff_n    = ((s_bytes == 4'd0) || (s_bytes > 4'd8)) ? 4'd8 : s_bytes;
  assign w_base     = s_sof ? CRC_INIT : r_crc;
  assign w_word_crc = crc_word(w_base, s_data);
  assign w_byte_crc = crc_byte(r_crc, r_tail_word[7:0]);
  assign w_cnt_inc  = (&r_beat_cnt) ? r_beat_cnt : (r_beat_cnt + CNT_W'(1));

  assign crc_valid = r_crc_valid;
  assign crc_out   = r_crc_out;
  assign beat_cnt  = r_beat_cnt;
  assign frame_err = r_frame_err;
`ifdef CRC_CHECK_EN
  assign crc_match = r_crc_match;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and next-value logic for the frame datapath.
  always_comb begin
    w_state_nxt     = r_state;
    w_crc_nxt       = r_crc;
    w_tail_word_nxt = r_tail_word;
    w_tail_left_nxt = r_tail_left;
    w_valid_nxt     = r_crc_valid;
    w_out_nxt       = r_crc_out;
    w_cnt_nxt       = r_beat_cnt;
    w_err_nxt       = 1'b0;
`ifdef CRC_CHECK_EN
    w_exp_nxt       = r_crc_exp;
    w_match_nxt     = r_crc_match;
`endif
    case (r_state)
      ST_IDLE, ST_RUN: begin
        if (w_fire) begin
          if (!s_sof && (r_state == ST_IDLE)) begin
            // Orphan beat: drop it, flag it, keep crc and count.
            w_err_nxt = 1'b1;
          end else begin
            w_err_nxt = s_sof && (r_state == ST_RUN);
            w_cnt_nxt = s_sof ? CNT_W'(1) : w_cnt_inc;
            if (!s_eof) begin
              w_crc_nxt   = w_word_crc;
              w_state_nxt = ST_RUN;
            end else begin
`ifdef CRC_CHECK_EN
              w_exp_nxt = crc_exp;
`endif
              if (w_eff_n == 4'd8) begin
                w_crc_nxt   = w_word_crc;
                w_out_nxt   = w_word_crc ^ CRC_XOROUT;
                w_valid_nxt = 1'b1;
                w_state_nxt = ST_DONE;
`ifdef CRC_CHECK_EN
                w_match_nxt = ((w_word_crc ^ CRC_XOROUT) == crc_exp);
`endif
              end else begin
                w_crc_nxt       = w_base;
                w_tail_word_nxt = s_data;
                w_tail_left_nxt = w_eff_n[TAIL_W-1:0];
                w_state_nxt     = ST_TAIL;
              end
            end
          end
        end
      end
      ST_TAIL: begin
        w_crc_nxt       = w_byte_crc;
        w_tail_word_nxt = {8'h00, r_tail_word[DATA_W-1:8]};
        w_tail_left_nxt = r_tail_left - 3'd1;
        if (r_tail_left == 3'd1) begin
          w_out_nxt   = w_byte_crc ^ CRC_XOROUT;
          w_valid_nxt = 1'b1;
          w_state_nxt = ST_DONE;
`ifdef CRC_CHECK_EN
          w_match_nxt = ((w_byte_crc ^ CRC_XOROUT) == r_crc_exp);
`endif
        end
      end
      ST_DONE: begin
        if (crc_ready) begin
          w_valid_nxt = 1'b0;
          w_crc_nxt   = CRC_INIT;
          w_state_nxt = ST_IDLE;
`ifdef CRC_CHECK_EN
          w_match_nxt = 1'b0;
`endif
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc       <= CRC_INIT;
      r_tail_word <= '0;
      r_tail_left <= '0;
      r_crc_valid <= 1'b0;
      r_crc_out   <= '0;
      r_beat_cnt  <= '0;
      r_frame_err <= 1'b0;
`ifdef CRC_CHECK_EN
      r_crc_exp   <= '0;
      r_crc_match <= 1'b0;
`endif
    end else begin
      r_crc       <= w_crc_nxt;
      r_tail_word <= w_tail_word_nxt;
      r_tail_left <= w_tail_left_nxt;
      r_crc_valid <= w_valid_nxt;
      r_crc_out   <= w_out_nxt;
      r_beat_cnt  <= w_cnt_nxt;
      r_frame_err <= w_err_nxt;
`ifdef CRC_CHECK_EN
      r_crc_exp   <= w_exp_nxt;
      r_crc_match <= w_match_nxt;
`endif
    end
  end

endmodule
